// File: rtl/outh_pkg.sv
// Shared constants for the output handler: default packet geometry and the
// round-robin priority encoding.
package outh_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_HOP_LSB = 48;
    localparam int DEF_HOP_W   = 8;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

endpackage

// File: rtl/output_handler_rr_arb2.sv
// Two-way round-robin arbiter: grants one of two requesters when the output
// buffer can accept, then hands priority to the other requester.
module rr_arb2
    import outh_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    prio_e prio_reg;
    prio_e prio_next;

    // A lone requester always wins; on contention prio breaks the tie.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        prio_next = prio_reg;
        if (accept) begin
            if (req_a && (!req_b || prio_reg == PRIO_A)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
        if (gnt_a) begin
            prio_next = PRIO_B;
        end else if (gnt_b) begin
            prio_next = PRIO_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= PRIO_A;
        end else begin
            prio_reg <= prio_next;
        end
    end

endmodule

// File: rtl/output_handler.sv
// Single-entry output buffer fed by a ring input (hop field halved) and a PE
// input. Optional drain counter port pkt_cnt is enabled by OUTH_PKT_CNT_EN.
module output_handler
    import outh_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int HOP_LSB = DEF_HOP_LSB,
    parameter int HOP_W   = DEF_HOP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fwd_v_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              fwd_v_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              fwd_en_a,
    output logic              fwd_en_b,
    output logic              out_v,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_rdy
`ifdef OUTH_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt
`endif
);

    logic              accept;
    logic              gnt_a;
    logic              gnt_b;
    logic              drain;
    logic              buf_v_reg;
    logic              buf_v_next;
    logic [DATA_W-1:0] buf_data_reg;
    logic [DATA_W-1:0] buf_data_next;
    logic [DATA_W-1:0] data_a_xform;

    // The entry frees up in the same cycle it drains, so a full buffer can
    // still take a new packet each cycle while downstream is ready.
    assign accept = ~buf_v_reg | out_rdy;
    assign drain  = buf_v_reg & out_rdy;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .req_a  (fwd_v_a),
        .req_b  (fwd_v_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    assign fwd_en_a = gnt_a;
    assign fwd_en_b = gnt_b;

    // Ring packets consume one hop: halve the hop field, keep everything else.
    always_comb begin
        data_a_xform = data_a;
        data_a_xform[HOP_LSB +: HOP_W] = data_a[HOP_LSB +: HOP_W] >> 1;
    end

    always_comb begin
        buf_v_next    = buf_v_reg;
        buf_data_next = buf_data_reg;
        if (gnt_a) begin
            buf_v_next    = 1'b1;
            buf_data_next = data_a_xform;
        end else if (gnt_b) begin
            buf_v_next    = 1'b1;
            buf_data_next = data_b;
        end else if (drain) begin
            buf_v_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v_reg    <= 1'b0;
            buf_data_reg <= '0;
        end else begin
            buf_v_reg    <= buf_v_next;
            buf_data_reg <= buf_data_next;
        end
    end

    assign out_v    = buf_v_reg;
    assign out_data = buf_data_reg;

`ifdef OUTH_PKT_CNT_EN
    logic [15:0] pkt_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_reg <= '0;
        end else if (drain) begin
            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_reg;
`endif

endmodule

// File: tb/tb_output_handler.sv
// Self-checking bench for output_handler: grant vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_output_handler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fwd_v_a;
    logic [63:0] data_a;
    logic        fwd_v_b;
    logic [63:0] data_b;
    logic        fwd_en_a;
    logic        fwd_en_b;
    logic        out_v;
    logic [63:0] out_data;
    logic        out_rdy;
`ifdef OUTH_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    output_handler #(.DATA_W(64), .HOP_LSB(48), .HOP_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fwd_v_a  (fwd_v_a),
        .data_a   (data_a),
        .fwd_v_b  (fwd_v_b),
        .data_b   (data_b),
        .fwd_en_a (fwd_en_a),
        .fwd_en_b (fwd_en_b),
        .out_v    (out_v),
        .out_data (out_data),
        .out_rdy  (out_rdy)
`ifdef OUTH_PKT_CNT_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    typedef struct {
        logic va;
        logic vb;
        logic rdy;
        logic ea;
        logic eb;
        logic ov;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ring packets arrive with the hop count (bits 55:48) halved.
    function automatic logic [63:0] ring_expect(input logic [63:0] d);
        logic [63:0] r;
        r = d;
        r[55:48] = d[55:48] / 8'd2;
        return r;
    endfunction

    task automatic drive(input logic va, input logic [63:0] da, input logic vb,
                         input logic [63:0] db, input logic rdy);
        fwd_v_a = va;
        data_a  = da;
        fwd_v_b = vb;
        data_b  = db;
        out_rdy = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Random-run model state
    logic [63:0] exp_q [$];
    bit          m_prio;
    int unsigned src_seq_a, src_seq_b, sb_seq_a, sb_seq_b;
    bit          prev_stall;
    logic [63:0] prev_data;

    initial begin
        logic [63:0] held, da, db, popped;
        bit acc, ega, egb;

        // Table: inputs in order from reset, with expected grants and out_v
        // before the edge, worked out from the arbitration rules.
        tbl[0]  = '{0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 1, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 1};
        tbl[3]  = '{1, 1, 1, 1, 0, 1};
        tbl[4]  = '{1, 1, 1, 0, 1, 1};
        tbl[5]  = '{1, 0, 1, 1, 0, 1};
        tbl[6]  = '{1, 0, 1, 1, 0, 1};
        tbl[7]  = '{0, 0, 1, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 1, 0};
        tbl[10] = '{1, 1, 1, 1, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 1};

        drive(1'b0, '0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        #12;
        check("reset_out_v", {63'd0, out_v}, 64'd0);
        check("reset_out_data", out_data, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].va, 64'h1111_2222_3333_4444, tbl[i].vb, 64'h5555_6666_7777_8888, tbl[i].rdy);
            @(negedge clk);
            check($sformatf("tbl%0d_en_a", i), {63'd0, fwd_en_a}, {63'd0, tbl[i].ea});
            check($sformatf("tbl%0d_en_b", i), {63'd0, fwd_en_b}, {63'd0, tbl[i].eb});
            check($sformatf("tbl%0d_out_v", i), {63'd0, out_v}, {63'd0, tbl[i].ov});
            $display("[TB] vec %0d va=%b vb=%b rdy=%b -> en_a=%b en_b=%b out_v=%b",
                     i, tbl[i].va, tbl[i].vb, tbl[i].rdy, fwd_en_a, fwd_en_b, out_v);
            @(posedge clk);
            #1;
        end

        // Single ring packet: hop 0x04 becomes 0x02, one-cycle latency.
        do_reset();
        drive(1'b1, 64'hAB04_CDEF_0123_4567, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("hop_en_a", {63'd0, fwd_en_a}, 64'd1);
        @(posedge clk);
        #1 drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("hop_out_v", {63'd0, out_v}, 64'd1);
        check("hop_out_data", out_data, 64'hAB02_CDEF_0123_4567);
        $display("[TB] hop packet out_data=%h", out_data);

        // Contention with ready downstream: strict a,b,a,b alternation.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            da = 64'hA0_00_0000_0000_0000 | (64'(8'h10 + k) << 48) | 64'(k);
            db = 64'hB0_00_0000_0000_0000 | (64'(8'h20 + k) << 48) | 64'(k);
            drive(1'b1, da, 1'b1, db, 1'b1);
            @(negedge clk);
            check($sformatf("rr%0d_en_a", k), {63'd0, fwd_en_a}, {63'd0, (k % 2) == 0});
            check($sformatf("rr%0d_en_b", k), {63'd0, fwd_en_b}, {63'd0, (k % 2) == 1});
            @(posedge clk);
            #1;
            check($sformatf("rr%0d_data", k), out_data, ((k % 2) == 0) ? ring_expect(da) : db);
            $display("[TB] rr step %0d out_data=%h", k, out_data);
        end

        // Full buffer, downstream stalled: no grants, stable output; then release.
        held = out_data;
        da   = 64'hA1_44_0000_0000_00AA;
        db   = 64'hB1_44_0000_0000_00BB;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, da, 1'b1, db, 1'b0);
            @(negedge clk);
            check($sformatf("stall%0d_en_a", k), {63'd0, fwd_en_a}, 64'd0);
            check($sformatf("stall%0d_en_b", k), {63'd0, fwd_en_b}, 64'd0);
            check($sformatf("stall%0d_out_v", k), {63'd0, out_v}, 64'd1);
            check($sformatf("stall%0d_data", k), out_data, held);
            $display("[TB] stall cycle %0d out_data=%h", k, out_data);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        @(negedge clk);
        check("release_en_a", {63'd0, fwd_en_a}, 64'd1);
        check("release_en_b", {63'd0, fwd_en_b}, 64'd0);
        @(posedge clk);
        #1 check("release_data", out_data, ring_expect(da));
        $display("[TB] release out_data=%h", out_data);

        // Async reset between edges while full; prio must come back as a-first.
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_v", {63'd0, out_v}, 64'd0);
        check("async_rst_data", out_data, 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 drive(1'b1, 64'hA2_08_0000_0000_0001, 1'b1, 64'hB2_08_0000_0000_0002, 1'b0);
        @(negedge clk);
        check("post_rst_en_a", {63'd0, fwd_en_a}, 64'd1);
        check("post_rst_en_b", {63'd0, fwd_en_b}, 64'd0);
        @(posedge clk);
        #1 check("post_rst_data", out_data, 64'hA2_04_0000_0000_0001);
        $display("[TB] post-reset out_data=%h", out_data);

        // Randomized traffic against a one-deep ordered queue model.
        do_reset();
        exp_q.delete();
        m_prio = 1'b0;
        src_seq_a = 0; src_seq_b = 0; sb_seq_a = 0; sb_seq_b = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            drive(1'($urandom_range(0, 1)), {8'hA5, 8'($urandom), 16'h0, src_seq_a},
                  1'($urandom_range(0, 1)), {8'hB6, 8'($urandom), 16'h0, src_seq_b},
                  $urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = (exp_q.size() == 0) || out_rdy;
            ega = acc && fwd_v_a && (!fwd_v_b || !m_prio);
            egb = acc && fwd_v_b && !ega;
            check("rnd_en_a", {63'd0, fwd_en_a}, {63'd0, ega});
            check("rnd_en_b", {63'd0, fwd_en_b}, {63'd0, egb});
            check("rnd_exclusive", {63'd0, fwd_en_a & fwd_en_b}, 64'd0);
            check("rnd_en_wo_v", {63'd0, (fwd_en_a & ~fwd_v_a) | (fwd_en_b & ~fwd_v_b)}, 64'd0);
            check("rnd_out_v", {63'd0, out_v}, {63'd0, exp_q.size() != 0});
            if (prev_stall) begin
                check("rnd_stall_stable", out_data, prev_data);
            end
            if (out_v && out_rdy && exp_q.size() != 0) begin
                popped = exp_q.pop_front();
                check("rnd_drain_data", out_data, popped);
                if (out_data[63:56] == 8'hA5) begin
                    check("rnd_seq_a", {32'd0, out_data[31:0]}, {32'd0, sb_seq_a});
                    sb_seq_a++;
                end else begin
                    check("rnd_seq_b", {32'd0, out_data[31:0]}, {32'd0, sb_seq_b});
                    sb_seq_b++;
                end
                $display("[TB] cyc %0d drain %h", cyc, out_data);
            end
            if (ega) begin
                exp_q.push_back(ring_expect(data_a));
                src_seq_a++;
                m_prio = 1'b1;
            end else if (egb) begin
                exp_q.push_back(data_b);
                src_seq_b++;
                m_prio = 1'b0;
            end
            prev_stall = out_v && !out_rdy;
            prev_data  = out_data;
            @(posedge clk);
            #1;
        end

`ifdef OUTH_PKT_CNT_EN
        // Counter wrap: 65534 drains to 0xFFFE, then two more wrap to 0.
        do_reset();
        check("cnt_reset", {48'd0, pkt_cnt}, 64'd0);
        drive(1'b1, 64'h0, 1'b0, '0, 1'b1);
        repeat (65535) @(posedge clk);
        #1 check("cnt_fffe", {48'd0, pkt_cnt}, 64'h0000_0000_0000_FFFE);
        $display("[TB] pkt_cnt=%h", pkt_cnt);
        repeat (2) @(posedge clk);
        #1 check("cnt_wrap", {48'd0, pkt_cnt}, 64'd0);
        $display("[TB] pkt_cnt=%h", pkt_cnt);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
